// File: rtl/secuenciador_multiciclo.sv
// Purpose: multicycle control sequencer; fetches, decodes and steps one instruction at a time.
// Latency: start -> first imem_req 1 cycle; CPI = a+1 (NOP/halt), a+2 (beq), a+3 (R/sw), a+4 (lw).
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; optional step gating holds DECODE.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 pulse; starts execution at PC 0 from IDLE or HALT
//   imem_req/addr/ack/data instruction memory fetch handshake
//   instruccion_r         instruction register driven into the datapath
//   zf                    ALU zero flag, resolves beq at the end of EXEC
//   reg_write_en          register-bank write strobe (WB only)
//   mem_write_en          RAM write strobe (MEM of sw only)
//   pc, busy, halted      program counter and status
//   instr_count           retired-instruction count, saturating
//   step                  single-step pulse (only when SEQ_STEP_EN is defined)
// Build option: define SEQ_STEP_EN to make DECODE wait for a step pulse.

module secuenciador_multiciclo #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instruccion_r,
  input  logic            zf,
  output logic            reg_write_en,
  output logic            mem_write_en,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     instr_count
`ifdef SEQ_STEP_EN
  ,
  input  logic            step
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] opcode;
  logic       decode_go;
  logic       retire;
  logic       restart;

  assign opcode    = instruccion_r[31:26];
  assign imem_addr = pc;
  assign restart   = ((state == IDLE) || (state == HALT)) && start;

`ifdef SEQ_STEP_EN
  assign decode_go = step;
`else
  assign decode_go = 1'b1;
`endif

  // Next state and retirement; retirement is flagged on the cycle that leaves
  // the instruction's final state so the count updates on that same edge.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (imem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        if (decode_go) begin
          case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_nxt = EXEC;
            OP_HALT: begin
              state_nxt = HALT;
              retire    = 1'b1;
            end
            default: begin
              state_nxt = FETCH;
              retire    = 1'b1;
            end
          endcase
        end
      end
      EXEC: begin
        case (opcode)
          OP_RTYPE:     state_nxt = WB;
          OP_LW, OP_SW: state_nxt = MEM;
          default: begin
            state_nxt = FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (opcode == OP_LW) begin
          state_nxt = WB;
        end else begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      WB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so strobes are clean,
  // single-cycle and cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      imem_req      <= 1'b0;
      instruccion_r <= 32'd0;
      reg_write_en  <= 1'b0;
      mem_write_en  <= 1'b0;
      pc            <= '0;
      busy          <= 1'b0;
      halted        <= 1'b0;
      instr_count   <= 16'd0;
    end else begin
      state        <= state_nxt;
      imem_req     <= (state_nxt == FETCH);
      reg_write_en <= (state_nxt == WB);
      // MEM is also visited by lw, which must not write RAM.
      mem_write_en <= (state_nxt == MEM) && (opcode == OP_SW);
      busy         <= (state_nxt != IDLE) && (state_nxt != HALT);
      halted       <= (state_nxt == HALT);

      if (restart) begin
        pc          <= '0;
        instr_count <= 16'd0;
      end else if (retire && (instr_count != 16'hFFFF)) begin
        instr_count <= instr_count + 16'd1;
      end

      if ((state == FETCH) && imem_ack) begin
        instruccion_r <= imem_data;
        pc            <= pc + PC_W'(1);
      end

      // pc already points past the beq; the low PC_W immediate bits, taken
      // modulo 2^PC_W, are exactly the sign-extended offset.
      if ((state == EXEC) && (opcode == OP_BEQ) && zf) begin
        pc <= pc + instruccion_r[PC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_multiciclo.sv
// Purpose: self-checking bench for secuenciador_multiciclo against an instruction-level model.
// Latency: checks fetch address, cycles per instruction, strobe counts, pc and count per instruction.
// Backpressure: random imem_ack latency; ack/start noise outside the states that may accept them.

module tb_secuenciador_multiciclo;

  localparam int PC_W = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic [31:0]     instruccion_r;
  logic            zf;
  logic            reg_write_en;
  logic            mem_write_en;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic [15:0]     instr_count;
`ifdef SEQ_STEP_EN
  logic            step;
`endif

  secuenciador_multiciclo #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instruccion_r (instruccion_r),
    .zf            (zf),
    .reg_write_en  (reg_write_en),
    .mem_write_en  (mem_write_en),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .instr_count   (instr_count)
`ifdef SEQ_STEP_EN
    ,
    .step          (step)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: instruction memory, architectural pc and retired count.
  logic [31:0] prog [256];
  int          m_pc;
  int          m_count;
  int          n_checks;
  int          n_errors;

  localparam logic [31:0] I_RTYPE = 32'h0022_1820;
  localparam logic [31:0] I_SW    = 32'hAC00_0004;
  localparam logic [31:0] I_LW    = 32'h8C00_0008;
  localparam logic [31:0] I_HALT  = 32'hFC00_0000;
  localparam logic [31:0] I_NOP   = 32'h0800_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(imem_req), 32'd0);
    chk({tag, "_addr"},  32'(imem_addr), 32'd0);
    chk({tag, "_ir"},    instruccion_r, 32'd0);
    chk({tag, "_rwe"},   32'(reg_write_en), 32'd0);
    chk({tag, "_mwe"},   32'(mem_write_en), 32'd0);
    chk({tag, "_pc"},    32'(pc), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_halt"},  32'(halted), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    int          r;
    logic [5:0]  op;
    logic [31:0] w;
    r = $urandom_range(0, 99);
    w = $urandom;
    if (r < 20)      op = 6'b000000;
    else if (r < 35) op = 6'b100011;
    else if (r < 50) op = 6'b101011;
    else if (r < 70) op = 6'b000100;
    else if (r < 74) op = 6'b111111;
    else begin
      op = 6'($urandom_range(1, 62));
      if (op == 6'b100011 || op == 6'b101011 || op == 6'b000100) op = 6'b000010;
    end
    return {op, w[25:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 32'd0;
    zf        = 1'b0;
`ifdef SEQ_STEP_EN
    step      = 1'b0;
`endif
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    m_pc    = 0;
    m_count = 0;
  endtask

  // Pulse start at a negedge; the fetch must begin on the very next cycle.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    m_pc    = 0;
    m_count = 0;
    chk("start_lat_req", 32'(imem_req), 32'd1);
    chk("start_pc", 32'(pc), 32'd0);
    chk("start_count", 32'(instr_count), 32'd0);
  endtask

  // Executes the instruction at the model pc. Entry: at a negedge in the first
  // FETCH cycle. Exit: at a negedge in the next FETCH cycle or in HALT.
  task automatic run_instr(input int a, input logic z);
    logic [31:0] ins;
    logic [5:0]  op;
    int          cyc, rw, mw, w, exp_c, exp_rw, exp_mw, np, imm;
    logic        stable, ir_ok, busy_ok;
    ins     = prog[m_pc];
    op      = ins[31:26];
    cyc     = 0;
    w       = 0;
    stable  = 1'b1;
    ir_ok   = 1'b1;
    busy_ok = 1'b1;
    rw      = 0;
    mw      = 0;
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
    for (int i = 1; i <= a; i++) begin
      if (!imem_req || (int'(imem_addr) != m_pc)) stable = 1'b0;
      imem_ack  = (i == a);
      imem_data = (i == a) ? ins : $urandom;
      start     = ($urandom_range(0, 3) == 0);
      cyc++;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    zf       = z;
    chk("addr_stable", 32'(stable), 32'd1);
    chk("ir_load", instruccion_r, ins);
`ifdef SEQ_STEP_EN
    w = $urandom_range(0, 10);
    for (int i = 0; i < w; i++) begin
      rw += int'(reg_write_en);
      mw += int'(mem_write_en);
      if (!busy) busy_ok = 1'b0;
      imem_ack = 1'b0;
      start    = ($urandom_range(0, 3) == 0);
      cyc++;
      @(negedge clk);
    end
    step = 1'b1;
`endif
    while (!imem_req && !halted && cyc < 40) begin
      rw += int'(reg_write_en);
      mw += int'(mem_write_en);
      if (instruccion_r != ins) ir_ok = 1'b0;
      if (!busy) busy_ok = 1'b0;
      imem_ack  = ($urandom_range(0, 1) == 1);
      imem_data = $urandom;
      start     = ($urandom_range(0, 3) == 0);
      cyc++;
      @(negedge clk);
`ifdef SEQ_STEP_EN
      step = 1'b0;
`endif
    end
    imem_ack = 1'b0;
    start    = 1'b0;

    exp_rw = 0;
    exp_mw = 0;
    case (op)
      6'b000000: begin exp_c = a + 3; exp_rw = 1; end
      6'b100011: begin exp_c = a + 4; exp_rw = 1; end
      6'b101011: begin exp_c = a + 3; exp_mw = 1; end
      6'b000100: exp_c = a + 2;
      default:   exp_c = a + 1;
    endcase
    exp_c += w;
    np = (m_pc + 1) % 256;
    if (op == 6'b000100 && z) begin
      imm = int'($signed(ins[7:0]));
      np  = (((m_pc + 1 + imm) % 256) + 256) % 256;
    end
    m_pc = np;
    if (m_count < 65535) m_count++;

    chk("cycles", 32'(cyc), 32'(exp_c));
    chk("reg_we_pulses", 32'(rw), 32'(exp_rw));
    chk("mem_we_pulses", 32'(mw), 32'(exp_mw));
    chk("ir_stable", 32'(ir_ok), 32'd1);
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("pc_after", 32'(pc), 32'(m_pc));
    chk("count_after", 32'(instr_count), 32'(m_count));
    chk("halted_after", 32'(halted), 32'(op == 6'b111111));
    chk("busy_after", 32'(busy), 32'(op != 6'b111111));
  endtask

  // HALT must hold pc/count and ignore ack noise.
  task automatic chk_hold();
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("hold_halted", 32'(halted), 32'd1);
    chk("hold_pc", 32'(pc), 32'(m_pc));
    chk("hold_count", 32'(instr_count), 32'(m_count));
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_strobes", 32'({reg_write_en, mem_write_en}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = I_NOP;
    do_reset();

    // R-type, sw, halt; then hold in HALT.
    prog[0] = I_RTYPE;
    prog[1] = I_SW;
    prog[2] = I_HALT;
    start_run();
    run_instr(2, 1'b0);
    run_instr(1, 1'b0);
    run_instr(3, 1'b0);
    chk_hold();

    // Restart from HALT; taken beq to 255, NOP wraps to 0, untaken beq, halt.
    prog[0]   = 32'h1000_00FE;
    prog[255] = I_NOP;
    prog[1]   = I_HALT;
    prog[2]   = I_NOP;
    start_run();
    run_instr(1, 1'b1);
    run_instr(2, 1'b0);
    run_instr(1, 1'b0);
    run_instr(1, 1'b0);

    // beq at 4 with offset -3: taken goes to 2, then untaken goes to 5.
    for (int i = 0; i < 4; i++) prog[i] = I_NOP;
    prog[4] = 32'h1000_FFFD;
    prog[5] = I_HALT;
    start_run();
    for (int i = 0; i < 4; i++) run_instr($urandom_range(1, 4), 1'($urandom_range(0, 1)));
    run_instr(1, 1'b1);
    run_instr(1, 1'b0);
    run_instr(2, 1'b0);
    run_instr(1, 1'b0);
    run_instr(1, 1'b0);

    // Reset while sw is in MEM: strobe and all outputs drop immediately.
    do_reset();
    prog[0] = I_SW;
    start_run();
    imem_ack  = 1'b1;
    imem_data = I_SW;
    @(negedge clk);
    imem_ack = 1'b0;
`ifdef SEQ_STEP_EN
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
`else
    @(negedge clk);
`endif
    @(negedge clk);
    chk("mem_strobe_in_mem", 32'(mem_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    chk("mwe_after_reset", 32'(mem_write_en), 32'd0);
    rst_n   = 1'b1;
    m_pc    = 0;
    m_count = 0;
    @(negedge clk);

    // Random programs with random ack latency and zf.
    for (int run = 0; run < 25; run++) begin
      do_reset();
      for (int i = 0; i < 256; i++) prog[i] = rand_instr();
      start_run();
      for (int k = 0; k < 30; k++) begin
        logic [5:0] cur_op;
        cur_op = prog[m_pc][31:26];
        run_instr($urandom_range(1, 4), 1'($urandom_range(0, 1)));
        if (cur_op == 6'b111111) break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
